// File: rtl/sample_framer_pkg.sv
// sample_framer_pkg: shared types for the sample framer
package sample_framer_pkg;
  typedef enum logic [1:0] {IDLE, SINGLE, STREAM, FLUSH} framer_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra pointer bit for full/empty
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/sample_framer.sv
// sample_framer: buffers a framed sample stream and replays it as go/finish/data
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             sample_last,
  output logic             sample_ready,
  input  logic             rf_error,
  output logic             rf_go,
  output logic             rf_finish,
  output logic [WIDTH-1:0] rf_data,
  output logic [7:0]       frame_count,
  output logic             underrun
);
  framer_state_t state;
  logic [WIDTH:0] head;
  logic [WIDTH-1:0] held;
  logic full, empty, pop;
  assign sample_ready = !full;
  // an error in STREAM blocks the pop so the rest of the frame is left for FLUSH
  assign pop = !empty && (state == IDLE || state == FLUSH || (state == STREAM && !rf_error));
  sync_fifo #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sample_valid && sample_ready),
    .pop   (pop),
    .din   ({sample_last, sample_in}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      rf_go       <= 1'b0;
      rf_finish   <= 1'b0;
      rf_data     <= '0;
      held        <= '0;
      frame_count <= '0;
      underrun    <= 1'b0;
    end else begin
      rf_go     <= 1'b0;
      rf_finish <= 1'b0;
      rf_data   <= '0;
      underrun  <= 1'b0;
      case (state)
        IDLE:
          if (!empty) begin
            rf_go   <= 1'b1;
            rf_data <= head[WIDTH-1:0];
            held    <= head[WIDTH-1:0];
            state   <= head[WIDTH] ? SINGLE : STREAM;
          end
        SINGLE: begin
          state <= IDLE;
          if (!rf_error) begin
            rf_finish   <= 1'b1;
            rf_data     <= held;
            frame_count <= frame_count + 8'd1;
          end
        end
        STREAM:
          if (rf_error) state <= FLUSH;
          else if (!empty) begin
            rf_data <= head[WIDTH-1:0];
            held    <= head[WIDTH-1:0];
            if (head[WIDTH]) begin
              rf_finish   <= 1'b1;
              frame_count <= frame_count + 8'd1;
              state       <= IDLE;
            end
          end else begin
            rf_data  <= held;
            underrun <= 1'b1;
          end
        FLUSH:
          if (!empty && head[WIDTH]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
